// File: rtl/arith_pkg.sv
// Shared widths for the small Vedic multiplier family.
package arith_pkg;
  localparam int OPW = 3;       // operand width
  localparam int PW  = 2 * OPW; // exact product width
endpackage

// File: rtl/full_adder.sv
// One-bit full adder; also serves as a half adder with cin tied low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/vedic_3bit.sv
// Registered 3x3 unsigned multiplier, vertical-and-crosswise column reduction.
module vedic_3bit
  import arith_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           in_valid,
  output logic [PW-1:0]  p,
  output logic           out_valid
);

  logic [OPW-1:0][OPW-1:0] pp;   // pp[i][j] = a[i] & b[j]
  logic [PW-1:0]           prod;
  logic                    c1, s2a, c2a, c2b, s3a, c3a, c3b, c4;
  logic [PW-1:0]           p_d, p_q;
  logic                    out_valid_d, out_valid_q;

  // Partial-product AND array
  always_comb begin
    pp = '0;
    for (int i = 0; i < OPW; i++)
      for (int j = 0; j < OPW; j++)
        pp[i][j] = a[i] & b[j];
  end

  // Column 1: two terms, half adder
  full_adder u_col1 (.a(pp[1][0]), .b(pp[0][1]), .cin(1'b0), .sum(prod[1]), .cout(c1));

  // Column 2: three products, then fold in column-1 carry
  full_adder u_col2a (.a(pp[2][0]), .b(pp[1][1]), .cin(pp[0][2]), .sum(s2a), .cout(c2a));
  full_adder u_col2b (.a(s2a), .b(c1), .cin(1'b0), .sum(prod[2]), .cout(c2b));

  // Column 3: two products plus first col-2 carry, then the second col-2 carry
  full_adder u_col3a (.a(pp[2][1]), .b(pp[1][2]), .cin(c2a), .sum(s3a), .cout(c3a));
  full_adder u_col3b (.a(s3a), .b(c2b), .cin(1'b0), .sum(prod[3]), .cout(c3b));

  // Column 4: top product plus both col-3 carries; its carry is the MSB
  full_adder u_col4 (.a(pp[2][2]), .b(c3a), .cin(c3b), .sum(prod[4]), .cout(c4));

  assign prod[0] = pp[0][0];
  assign prod[5] = c4;

  // Output stage next-state: load on valid, otherwise hold (blocks X on idle operands)
  always_comb begin
    p_d         = p_q;
    out_valid_d = in_valid;
    if (in_valid) p_d = prod;
  end

  // Output register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vedic_3bit.sv
// Directed bench for vedic_3bit: reset, products, corners, hold, sweep, mid-stream reset.
module tb_vedic_3bit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] a = 3'd7;
  logic [2:0] b = 3'd7;
  logic       in_valid = 1'b1;
  logic [5:0] p;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  vedic_3bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .p(p), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one input beat, clock it, then check registered outputs #1 after the edge.
  task automatic step(input logic [2:0] av, input logic [2:0] bv, input logic v,
                      input logic [5:0] exp_p, input logic exp_v, input string tag);
    a = av; b = bv; in_valid = v;
    @(posedge clk); #1;
    check({tag, "_p"}, p, exp_p);
    check({tag, "_vld"}, {5'd0, out_valid}, {5'd0, exp_v});
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between
    #1 rst = 1'b1;
    #1;
    check("rst_p", p, 6'd0);
    check("rst_vld", {5'd0, out_valid}, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products
    step(3'd1, 3'd2, 1'b1, 6'd2,  1'b1, "m1x2");
    step(3'd2, 3'd4, 1'b1, 6'd8,  1'b1, "m2x4");
    step(3'd4, 3'd5, 1'b1, 6'd20, 1'b1, "m4x5");
    step(3'd5, 3'd6, 1'b1, 6'd30, 1'b1, "m5x6");
    step(3'd6, 3'd7, 1'b1, 6'd42, 1'b1, "m6x7");

    // Corners
    step(3'd0, 3'd5, 1'b1, 6'd0,  1'b1, "m0x5");
    step(3'd7, 3'd0, 1'b1, 6'd0,  1'b1, "m7x0");
    step(3'd7, 3'd7, 1'b1, 6'd49, 1'b1, "m7x7");
    step(3'd1, 3'd1, 1'b1, 6'd1,  1'b1, "m1x1");

    // Hold, including X operands while idle
    step(3'd3, 3'd3, 1'b1, 6'd9, 1'b1, "hold_load");
    step(3'd5, 3'd5, 1'b0, 6'd9, 1'b0, "hold_idle");
    step(3'bxxx, 3'bxxx, 1'b0, 6'd9, 1'b0, "hold_x");

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        step(3'(i), 3'(j), 1'b1, 6'(i * j), 1'b1, $sformatf("sw%0dx%0d", i, j));

    // Mid-stream reset
    step(3'd6, 3'd7, 1'b1, 6'd42, 1'b1, "mid_6x7");
    rst = 1'b1;
    #1;
    check("mid_rst_p", p, 6'd0);
    check("mid_rst_vld", {5'd0, out_valid}, 6'd0);
    #1 rst = 1'b0;
    step(3'd5, 3'd5, 1'b1, 6'd25, 1'b1, "mid_5x5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
